// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and sizing for the program loader
package prog_loader_pkg;
  localparam int IMEM_WORDS = 256;
  localparam int IMEM_AW    = 8;
  localparam int DMEM_BYTES = 32;
  localparam int DMEM_AW    = 5;
  localparam int HDR_BYTES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_HDR_HI, ST_HDR_LO, ST_WORD, ST_DATA, ST_RUN, ST_ERR
  } state_e;

  // One extra bit so a full-depth load (N = IMEM_WORDS) reaches its end count without wrapping.
  typedef logic [IMEM_AW:0]         widx_t;
  typedef logic [HDR_BYTES*8-1:0]   hdr_t;
endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream valid/ready link from host to loader
interface prog_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);
endinterface

// File: rtl/prog_loader_b2w.sv
// rtl/prog_loader_b2w.sv - byte-to-word assembler: big-endian 4-byte shift with a one-cycle word_valid pulse
module prog_loader_b2w (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        last_o
);
  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en_i && (cnt_q == 2'd3);
      if (en_i) begin
        word_q <= {word_q[23:0], byte_i};
        cnt_q  <= cnt_q + 2'd1;
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign last_o       = (cnt_q == 2'd3);
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - clears IMEM/DMEM, streams in a program and operand, then releases the CPU
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_req_i,
  prog_loader_if.slave       byte_if,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_data_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [7:0]         dmem_data_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               err_o
);
  state_e             state_q;
  widx_t              idx_q, idx_d;
  hdr_t               n_q, n_d;
  logic [IMEM_AW-1:0] wr_addr_q;
  logic [7:0]         dbyte_q;
  logic               dwr_q, start_q, busy_q, err_q;

  logic        xfer, clearing, dclear, dwrite;
  logic        asm_valid, asm_last;
  logic [31:0] asm_word;

  assign clearing = (state_q == ST_CLEAR);
  assign dclear   = clearing && (idx_q < widx_t'(DMEM_BYTES));
  assign dwrite   = (state_q == ST_DATA) && dwr_q;
  assign byte_if.byte_ready = (state_q inside {ST_HDR_HI, ST_HDR_LO, ST_WORD}) ||
                              ((state_q == ST_DATA) && !dwr_q);
  assign xfer  = byte_if.byte_valid && byte_if.byte_ready;
  assign idx_d = idx_q + widx_t'(1);
  assign n_d   = {n_q[15:8], byte_if.byte_data};

  // A new load request also flushes any partial word held in the assembler.
  prog_loader_b2w u_b2w (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (load_req_i || clearing),
    .en_i         (xfer && (state_q == ST_WORD)),
    .byte_i       (byte_if.byte_data),
    .word_o       (asm_word),
    .word_valid_o (asm_valid),
    .last_o       (asm_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      wr_addr_q <= '0;
      dbyte_q   <= '0;
      dwr_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (load_req_i) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      n_q     <= '0;
      dwr_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (idx_q == widx_t'(IMEM_WORDS - 1)) begin
            state_q <= ST_HDR_HI;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_d;
          end
        end
        ST_HDR_HI: begin
          if (xfer) begin
            n_q     <= {byte_if.byte_data, 8'h00};
            state_q <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (xfer) begin
            n_q <= n_d;
            if (n_d > hdr_t'(IMEM_WORDS)) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else if (n_d == '0) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_WORD;
              idx_q   <= '0;
            end
          end
        end
        ST_WORD: begin
          if (xfer && asm_last) begin
            wr_addr_q <= idx_q[IMEM_AW-1:0];
            idx_q     <= idx_d;
            if (idx_d == widx_t'(n_q)) state_q <= ST_DATA;
          end
        end
        // The operand write cycle is also the cycle that hands over to RUN.
        ST_DATA: begin
          if (dwr_q) begin
            state_q <= ST_RUN;
            dwr_q   <= 1'b0;
            start_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            dbyte_q <= byte_if.byte_data;
            dwr_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we_o   = clearing || asm_valid;
  assign imem_addr_o = clearing ? idx_q[IMEM_AW-1:0] : (asm_valid ? wr_addr_q : '0);
  assign imem_data_o = (asm_valid && !clearing) ? asm_word : '0;
  assign dmem_we_o   = dclear || dwrite;
  assign dmem_addr_o = dclear ? idx_q[DMEM_AW-1:0] : '0;
  assign dmem_data_o = dwrite ? dbyte_q : '0;
  assign start_o     = start_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven bench with a write scoreboard for prog_loader
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0, w1, w2;
    logic [7:0]  d;
    int          gapmax;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load_req = 1'b0;
  logic               imem_we, dmem_we, start, busy, err;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [7:0]         dmem_data;

  prog_loader_if bus();

  prog_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_req_i  (load_req),
    .byte_if     (bus),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_data_o (imem_data),
    .dmem_we_o   (dmem_we),
    .dmem_addr_o (dmem_addr),
    .dmem_data_o (dmem_data),
    .start_o     (start),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  wr_t  imem_q[$];
  wr_t  dmem_q[$];
  wr_t  mon_e;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (imem_q.size() == 0) chk("imem_unexpected_we", 32'(imem_we), 32'd0);
      else begin
        mon_e = imem_q.pop_front();
        chk("imem_addr", 32'(imem_addr), 32'(mon_e.addr));
        chk("imem_data", imem_data, mon_e.data);
      end
    end
    if (dmem_we === 1'b1) begin
      if (dmem_q.size() == 0) chk("dmem_unexpected_we", 32'(dmem_we), 32'd0);
      else begin
        mon_e = dmem_q.pop_front();
        chk("dmem_addr", 32'(dmem_addr), 32'(mon_e.addr));
        chk("dmem_data", 32'(dmem_data), mon_e.data);
      end
    end
  end

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    logic [15:0] ii;
    ii = 16'(i);
    case (i)
      0:       return v.w0;
      1:       return v.w1;
      2:       return v.w2;
      default: return {ii[7:0], ~ii[7:0], 8'h5A, ii[15:8]};
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    if (!got) chk("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit first, input int gapmax);
    int g, waited;
    if (!first) begin
      g = int'($urandom_range(gapmax));
      repeat (g) begin
        @(negedge clk);
        chk("ready_in_gap", 32'(bus.byte_ready), 32'd1);
        @(posedge clk); #1;
      end
    end
    send_byte(b, waited);
    if (!first) chk("ready_no_stall", 32'(waited), 32'd0);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    for (int i = 0; i < IMEM_WORDS; i++) imem_q.push_back('{i, 32'd0});
    for (int i = 0; i < DMEM_BYTES; i++) dmem_q.push_back('{i, 32'd0});
    @(posedge clk); #1;
    load_req = 1'b0;
    @(negedge clk);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_err_clr", 32'(err), 32'd0);
    chk("load_start_drop", 32'(start), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] w;
    pulse_load();
    send(v.n[15:8], 1'b1, 0);
    send(v.n[7:0], 1'b0, v.gapmax);
    if (v.exp_err) begin
      @(negedge clk);
      chk("err_set", 32'(err), 32'd1);
      chk("err_ready", 32'(bus.byte_ready), 32'd0);
      chk("err_start", 32'(start), 32'd0);
      chk("err_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i < int'(v.n); i++) begin
      w = word_of(v, i);
      send(w[31:24], 1'b0, v.gapmax);
      send(w[23:16], 1'b0, v.gapmax);
      send(w[15:8],  1'b0, v.gapmax);
      send(w[7:0],   1'b0, v.gapmax);
      imem_q.push_back('{i, w});
    end
    send(v.d, 1'b0, v.gapmax);
    dmem_q.push_back('{0, {24'd0, v.d}});
    @(negedge clk);
    chk("dwrite_we", 32'(dmem_we), 32'd1);
    chk("dwrite_start_low", 32'(start), 32'd0);
    @(negedge clk);
    chk("run_start", 32'(start), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
    chk("imem_pending", 32'(imem_q.size()), 32'd0);
    chk("dmem_pending", 32'(dmem_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_data"}, imem_data, 32'd0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_dmem_addr"}, 32'(dmem_addr), 32'd0);
    chk({tag, "_dmem_data"}, 32'(dmem_data), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    //           n        w0            w1            w2            d      gap err
    vecs[0] = '{16'd3,   32'h20080005, 32'h00000000, 32'hAC080004, 8'h05, 0, 1'b0};
    vecs[1] = '{16'd0,   32'h0,        32'h0,        32'h0,        8'h07, 0, 1'b0};
    vecs[2] = '{16'd257, 32'h0,        32'h0,        32'h0,        8'h00, 0, 1'b1};
    vecs[3] = '{16'd256, 32'h01020304, 32'hFFFFFFFF, 32'h80000001, 8'h3C, 0, 1'b0};
    vecs[4] = '{16'd2,   32'h11223344, 32'h55667788, 32'h0,        8'h99, 0, 1'b0};
    vecs[5] = '{16'd2,   32'h11223344, 32'h55667788, 32'h0,        8'h99, 3, 1'b0};
    vecs[6] = '{16'd1,   32'hCAFEF00D, 32'h0,        32'h0,        8'hFF, 2, 1'b0};

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_idle_outputs("reset");
    end
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) run_load(vecs[t]);

    // Reset in the middle of word 1: no strobes may follow the reset edge.
    pulse_load();
    send(8'h00, 1'b1, 0);
    send(8'h02, 1'b0, 0);
    w = 32'hDEADBEEF;
    send(w[31:24], 1'b0, 0);
    send(w[23:16], 1'b0, 0);
    send(w[15:8],  1'b0, 0);
    send(w[7:0],   1'b0, 0);
    imem_q.push_back('{0, w});
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      chk_idle_outputs("midreset");
      @(posedge clk); #1;
    end
    rst = 1'b0;
    chk("midreset_imem_pending", 32'(imem_q.size()), 32'd0);
    chk("midreset_dmem_pending", 32'(dmem_q.size()), 32'd0);

    run_load(vecs[4]);

    // Reload from RUN: start drops at once and the clear pass runs again.
    pulse_load();
    repeat (IMEM_WORDS + 4) @(posedge clk);
    #1;
    chk("reload_imem_pending", 32'(imem_q.size()), 32'd0);
    chk("reload_dmem_pending", 32'(dmem_q.size()), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_ready", 32'(bus.byte_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware counterpart to bench-side program preload. Receives a byte stream on a valid/ready interface and clears instruction and data memory.
- Writes the program words and the input operand n (data memory 0x00), then releases the CPU with start.
- Sits between the host/debug link and the CPU's Instruction_Memory and Data_Memory write ports. Drives the CPU start_i.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words
IMEM_AW, 8, instruction word address width (log2 IMEM_WORDS)
DMEM_BYTES, 32, data memory depth in bytes
DMEM_AW, 5, data byte address width (log2 DMEM_BYTES)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
load_req_i  in  1  one-cycle pulse: begin (re)load
byte_valid_i  in  1  byte_data_i valid
byte_data_i  in  8  stream byte
byte_ready_o  out  1  loader accepts byte this cycle
imem_we_o  out  1  instruction memory write strobe
imem_addr_o  out  IMEM_AW  instruction word index
imem_data_o  out  32  instruction word
dmem_we_o  out  1  data memory byte write strobe
dmem_addr_o  out  DMEM_AW  data byte address
dmem_data_o  out  8  data byte
start_o  out  1  CPU start, to start_i
busy_o  out  1  load in progress
err_o  out  1  header count exceeded IMEM_WORDS, sticky until next load_req_i/reset

Behaviour:
- Reset: state IDLE. All outputs are 0, including start_o and err_o. Byte assembly register and counters are 0.
- Transfer: a byte transfers on a cycle with byte_valid_i & byte_ready_o. byte_ready_o is high only in HDR_HI, HDR_LO, WORD, DATA.
- Stream format:
  - N, 16-bit, big-endian.
  - N instruction words, each big-endian (MSB byte first).
  - One operand byte.
- FSM states: IDLE, CLEAR, HDR_HI, HDR_LO, WORD, DATA, RUN, ERR.
- IDLE: on load_req_i, go to CLEAR, clear err_o, set busy_o.
- CLEAR:
  - Lasts IMEM_WORDS cycles, counter i = 0..IMEM_WORDS-1.
  - Each cycle: imem_we_o=1, imem_addr_o=i, imem_data_o=0.
  - While i<DMEM_BYTES, also dmem_we_o=1, dmem_addr_o=i, dmem_data_o=0.
  - After i=IMEM_WORDS-1, go to HDR_HI.
- HDR_HI / HDR_LO: capture N[15:8] then N[7:0].
  - On the HDR_LO transfer: if N>IMEM_WORDS go to ERR; if N=0 go to DATA; else go to WORD with word index 0.
- WORD:
  - Shift each accepted byte into the 32-bit assembly register (first byte lands in [31:24]).
  - The cycle after the 4th byte transfer: imem_we_o=1 for one cycle, with imem_addr_o = index and imem_data_o = the word.
  - byte_ready_o stays high during that write cycle. Bytes are accepted back-to-back with zero bubbles, so throughput is 1 byte/cycle.
  - After word N-1 is accepted, go to DATA; its write strobe issues in the first DATA cycle.
- DATA:
  - Accept one byte. Next cycle: dmem_we_o=1, dmem_addr_o=0, dmem_data_o=byte.
  - Same cycle, go to RUN.
- RUN:
  - start_o=1, busy_o=0; held indefinitely.
  - load_req_i in RUN: start_o drops next cycle, go to CLEAR. CPU is re-held.
- ERR: err_o=1, busy_o=0, start_o=0, byte_ready_o=0. Leave only on load_req_i (to CLEAR) or reset.
- load_req_i in any busy state (CLEAR..DATA): restart at CLEAR with counters zeroed. Partial words are discarded.
- Gaps in byte_valid_i: state and partial word are held, no timeout.
- Reset mid-operation: immediate return to IDLE next edge. No further strobes issue after the reset edge.
- imem_we_o and dmem_we_o are never asserted outside CLEAR/WORD/DATA write cycles.
- Index width: word index uses IMEM_AW+1 bits, so N=IMEM_WORDS completes without wrap.

Decomposition:
- Shared package: FSM state enum (IDLE..ERR), IMEM_WORDS/DMEM_BYTES defaults, header byte count constant (2).
- One natural sub-module: byte_to_word_assembler (4-byte shift register + byte counter + word_valid pulse), used in WORD.

Test Plan:
- Reset held 3 cycles, then released with no load_req_i -> all outputs 0, state IDLE.
- Clear pass:
  - Stimulus: load_req_i, then stream 00 03, words 0x20080005, 0x00000000, 0xAC080004, byte 0x05.
  - Response: 256 clear strobes with 32 dmem clears during the first 32, then imem writes at addr 0,1,2 with those values.
  - Then dmem_we_o addr 0 data 0x05, and start_o=1 the following cycle.
- N=0, byte 0x07 -> only clears plus dmem addr 0 = 0x07, start_o=1; no imem write after CLEAR.
- Header 01 01 (N=257) -> err_o=1, byte_ready_o=0, start_o=0. Next load_req_i clears err_o.
- Overflow bound, N=256: last write at imem addr 255.
- Randomized valid gaps on a 2-word load -> identical memory writes to the gapless run, and byte_ready_o timing is unaffected by gaps.
- Interrupted load and reload:
  - rst_i asserted after 2 bytes of word 1 -> no further strobes, outputs 0.
  - A fresh load then completes normally.
  - load_req_i in RUN -> start_o drops next cycle and CLEAR restarts.
